pmu_counter_access: RTL

//  Counter-clock-domain access engine for the PMU counter bank. It terminates the
//  4-phase req/ack handshakes issued from the noc_clk AXI-lite register slave and

---
 rtl/pmu_counter_access.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pmu_counter_access.sv
// pmu_counter_access
// Counter-clock-domain end of the PMU register path. Accepts 4-phase read and
// write handshakes from the noc_clk AXI-lite slave, synchronizes the request
// levels, decodes tile/register and performs one registered access on the bank.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a synced request; write wins if both are high
// ST_WRITE  | write strobe presented to the bank for this one cycle
// ST_READ   | bank read mux addressed; bank data sampled at end of cycle
// ST_ACK_WR | wr_ack_o held high until the synced write request drops
// ST_ACK_RD | rd_ack_o and rd_data_o held until the synced read request drops
module pmu_counter_access #(
    parameter int TILE_COUNT  = 1,
    parameter int NUM_REGS    = 24,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                counter_clk,
    input  logic                rst,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_ack_o,
    input  logic                wr_req_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    output logic                wr_ack_o,
    output logic                err_o,
    output logic [ADDR_W-6:0]   bank_rd_tile_o,
    output logic [4:0]          bank_rd_reg_o,
    input  logic [DATA_W-1:0]   bank_rd_data_i,
    output logic                bank_wr_en_o,
    output logic                bank_wr_bcast_o,
    output logic [ADDR_W-6:0]   bank_wr_tile_o,
    output logic [4:0]          bank_wr_reg_o,
    output logic [DATA_W-1:0]   bank_wr_data_o
);

    localparam int TW = ADDR_W - 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ACK_WR,
        ST_ACK_RD
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
    logic                   acc_ok_q, acc_ok_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   rd_ack_q, rd_ack_d;
    logic                   wr_ack_q, wr_ack_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          bank_rd_tile_q, bank_rd_tile_d;
    logic [4:0]             bank_rd_reg_q, bank_rd_reg_d;
    logic                   bank_wr_en_q, bank_wr_en_d;
    logic                   bank_wr_bcast_q, bank_wr_bcast_d;
    logic [TW-1:0]          bank_wr_tile_q, bank_wr_tile_d;
    logic [4:0]             bank_wr_reg_q, bank_wr_reg_d;
    logic [DATA_W-1:0]      bank_wr_data_q, bank_wr_data_d;

    logic                   rd_sync, wr_sync;
    logic [TW-1:0]          rd_tile, wr_tile;
    logic [4:0]             rd_reg, wr_reg;
    logic                   rd_bcast, wr_bcast;
    logic                   rd_ok, wr_ok;

    assign rd_sync  = rd_sync_q[SYNC_STAGES-1];
    assign wr_sync  = wr_sync_q[SYNC_STAGES-1];

    // Address fields are only looked at once the synced request is seen, so
    // the requester has held them stable for several counter_clk cycles.
    assign rd_tile  = rd_addr_i[ADDR_W-1:5];
    assign rd_reg   = rd_addr_i[4:0];
    assign wr_tile  = wr_addr_i[ADDR_W-1:5];
    assign wr_reg   = wr_addr_i[4:0];
    assign rd_bcast = &rd_tile;
    assign wr_bcast = &wr_tile;
    assign rd_ok    = (int'(rd_reg) < NUM_REGS) && (rd_bcast || (int'(rd_tile) < TILE_COUNT));
    assign wr_ok    = (int'(wr_reg) < NUM_REGS) && (wr_bcast || (int'(wr_tile) < TILE_COUNT));

    // Next-state and next-output computation for the synchronizers and the FSM.
    always_comb begin
        rd_sync_d       = {rd_sync_q[SYNC_STAGES-2:0], rd_req_i};
        wr_sync_d       = {wr_sync_q[SYNC_STAGES-2:0], wr_req_i};
        state_d         = state_q;
        acc_ok_d        = acc_ok_q;
        rd_data_d       = rd_data_q;
        rd_ack_d        = rd_ack_q;
        wr_ack_d        = wr_ack_q;
        err_d           = 1'b0;
        bank_rd_tile_d  = bank_rd_tile_q;
        bank_rd_reg_d   = bank_rd_reg_q;
        bank_wr_en_d    = 1'b0;
        bank_wr_bcast_d = 1'b0;
        bank_wr_tile_d  = bank_wr_tile_q;
        bank_wr_reg_d   = bank_wr_reg_q;
        bank_wr_data_d  = bank_wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_sync) begin
                    state_d         = ST_WRITE;
                    acc_ok_d        = wr_ok;
                    bank_wr_tile_d  = wr_tile;
                    bank_wr_reg_d   = wr_reg;
                    bank_wr_data_d  = wr_data_i;
                    bank_wr_en_d    = wr_ok;
                    bank_wr_bcast_d = wr_ok && wr_bcast;
                end else if (rd_sync) begin
                    state_d        = ST_READ;
                    acc_ok_d       = rd_ok;
                    // broadcast reads are served from tile 0
                    bank_rd_tile_d = rd_bcast ? '0 : rd_tile;
                    bank_rd_reg_d  = rd_reg;
                end
            end
            ST_WRITE: begin
                state_d  = ST_ACK_WR;
                wr_ack_d = 1'b1;
                err_d    = !acc_ok_q;
            end
            ST_READ: begin
                state_d   = ST_ACK_RD;
                rd_ack_d  = 1'b1;
                rd_data_d = acc_ok_q ? bank_rd_data_i : '0;
                err_d     = !acc_ok_q;
            end
            ST_ACK_WR: begin
                if (!wr_sync) begin
                    state_d  = ST_IDLE;
                    wr_ack_d = 1'b0;
                end
            end
            ST_ACK_RD: begin
                if (!rd_sync) begin
                    state_d  = ST_IDLE;
                    rd_ack_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_ack_d = 1'b0;
                wr_ack_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge counter_clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            rd_sync_q       <= '0;
            wr_sync_q       <= '0;
            acc_ok_q        <= 1'b0;
            rd_data_q       <= '0;
            rd_ack_q        <= 1'b0;
            wr_ack_q        <= 1'b0;
            err_q           <= 1'b0;
            bank_rd_tile_q  <= '0;
            bank_rd_reg_q   <= '0;
            bank_wr_en_q    <= 1'b0;
            bank_wr_bcast_q <= 1'b0;
            bank_wr_tile_q  <= '0;
            bank_wr_reg_q   <= '0;
            bank_wr_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            rd_sync_q       <= rd_sync_d;
            wr_sync_q       <= wr_sync_d;
            acc_ok_q        <= acc_ok_d;
            rd_data_q       <= rd_data_d;
            rd_ack_q        <= rd_ack_d;
            wr_ack_q        <= wr_ack_d;
            err_q           <= err_d;
            bank_rd_tile_q  <= bank_rd_tile_d;
            bank_rd_reg_q   <= bank_rd_reg_d;
            bank_wr_en_q    <= bank_wr_en_d;
            bank_wr_bcast_q <= bank_wr_bcast_d;
            bank_wr_tile_q  <= bank_wr_tile_d;
            bank_wr_reg_q   <= bank_wr_reg_d;
            bank_wr_data_q  <= bank_wr_data_d;
        end
    end

    assign rd_data_o       = rd_data_q;
    assign rd_ack_o        = rd_ack_q;
    assign wr_ack_o        = wr_ack_q;
    assign err_o           = err_q;
    assign bank_rd_tile_o  = bank_rd_tile_q;
    assign bank_rd_reg_o   = bank_rd_reg_q;
    assign bank_wr_en_o    = bank_wr_en_q;
    assign bank_wr_bcast_o = bank_wr_bcast_q;
    assign bank_wr_tile_o  = bank_wr_tile_q;
    assign bank_wr_reg_o   = bank_wr_reg_q;
    assign bank_wr_data_o  = bank_wr_data_q;

endmodule
